// File: rtl/memory_read_unit.sv
// rtl/memory_read_unit.sv - issues one MM2S read command and unpacks the returned 32-bit stream into bytes
// Length is checked against the request; surplus words are drained and flagged.
module memory_read_unit #(
  parameter int         BTT_WIDTH = 23,
  parameter logic [3:0] CMD_TAG   = 4'h0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [31:0]          startAddress,
  input  logic [BTT_WIDTH-1:0] byteCount,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [71:0]          commandData,
  output logic                 commandPulse,
  input  logic                 senderCommandReady,
  input  logic [31:0]          dataIn,
  input  logic                 dataInPulse,
  output logic                 dataInReady,
  input  logic                 lastData,
  input  logic [3:0]           keepData,
  output logic [7:0]           byteOut,
  output logic                 bytePulse,
  input  logic                 byteReady
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_RECV  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [71:0]          cmd_q, cmd_d;
  logic [BTT_WIDTH-1:0] bc_q, bc_d;
  logic [BTT_WIDTH:0]   rx_q, rx_d;
  logic                 err_q, err_d;
  logic                 bufv_q, bufv_d;
  logic [31:0]          data_q, data_d;
  logic [3:0]           keep_q, keep_d;
  logic                 last_q, last_d;
  logic [1:0]           lane_q, lane_d;

  logic                 byte_hs, word_hs, final_byte, hit_count;
  logic [BTT_WIDTH:0]   rx_next;

  // keep is contiguous from lane 0, so the word ends at lane 3 or the first cleared lane
  assign final_byte = (lane_q == 2'd3) || !keep_q[lane_q + 2'd1];
  assign rx_next    = rx_q + 1'b1;
  assign hit_count  = (rx_next == {1'b0, bc_q});

  assign bytePulse    = (state_q == S_RECV) && bufv_q;
  assign byte_hs      = bytePulse && byteReady;
  assign dataInReady  = (state_q == S_DRAIN) ||
                        ((state_q == S_RECV) &&
                         (!bufv_q || (byte_hs && final_byte && !last_q && !hit_count)));
  assign word_hs      = dataInReady && dataInPulse;
  assign byteOut      = bytePulse ? data_q[{lane_q, 3'b000} +: 8] : 8'h00;
  assign commandPulse = (state_q == S_CMD);
  assign commandData  = cmd_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FIN);
  assign error        = err_q;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    bc_d    = bc_q;
    rx_d    = rx_q;
    err_d   = err_q;
    bufv_d  = bufv_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    lane_d  = lane_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          rx_d  = '0;
          bc_d  = byteCount;
          if (byteCount != '0) begin
            cmd_d                  = '0;
            cmd_d[BTT_WIDTH-1:0]   = byteCount;
            cmd_d[23]              = 1'b1;
            cmd_d[30]              = 1'b1;
            cmd_d[63:32]           = startAddress;
            cmd_d[67:64]           = CMD_TAG;
            state_d                = S_CMD;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_CMD: begin
        if (senderCommandReady) state_d = S_RECV;
      end
      S_RECV: begin
        if (byte_hs) begin
          rx_d = rx_next;
          if (final_byte && last_q) begin
            err_d   = !hit_count;
            bufv_d  = 1'b0;
            state_d = S_FIN;
          end else if (hit_count) begin
            // request satisfied: surplus in a last word is an error, otherwise drain to last
            err_d   = err_q | last_q;
            bufv_d  = 1'b0;
            state_d = last_q ? S_FIN : S_DRAIN;
          end else if (final_byte) begin
            bufv_d = 1'b0;
          end else begin
            lane_d = lane_q + 2'd1;
          end
        end
        if (word_hs) begin
          data_d = dataIn;
          keep_d = keepData;
          last_d = lastData;
          lane_d = 2'd0;
          bufv_d = keepData[0];
          if (!keepData[0] && lastData) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end
        end
      end
      S_DRAIN: begin
        if (dataInPulse) begin
          if (keepData != 4'h0) err_d = 1'b1;
          if (lastData) state_d = S_FIN;
        end
      end
      S_FIN: begin
        bufv_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      bc_q    <= '0;
      rx_q    <= '0;
      err_q   <= 1'b0;
      bufv_q  <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      bc_q    <= bc_d;
      rx_q    <= rx_d;
      err_q   <= err_d;
      bufv_q  <= bufv_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      lane_q  <= lane_d;
    end
  end

endmodule
